ni_response_order_ctrl: RTL and testbench
=========================================

# ni_response_order_ctrl

Multi-entry outstanding-transaction controller for the NI target response path. It records every request the NI issues that expects a response (target ID, read/write type) in an in-order tracking queue, and gates acceptance of returning response packets against the oldest entry. It retires entries on response completion and flags out-of-order or missing responses. It sits between the NI request side and the response depacketiser, and it allows up to DEPTH transactions to be in flight.

## Interface
- DEPTH, 4, number of tracking entries; power of two, at least 2.
- SRCW, 5, source/target ID width (`SOURCEWD` in the NoC build).
- TIMEOUT, 255, cycles a head entry may wait for a response before it is dropped; 1..65535.

- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  NI request issued that awaits a response; one push per cycle.
- req_is_read  in  1  1 = read (data response), 0 = write ack.
- req_target  in  SRCW  ID of the target addressed.
- req_ready  out  1  entry available (`!full`); a push while 0 is ignored.
- rsp_valid  in  1  head flit of a response packet present.
- rsp_source  in  SRCW  source ID carried in the response header.
- rsp_done  in  1  tail flit of the accepted response consumed.
- rsp_accept  out  1  combinational; response matches head entry and is accepted.
- head_is_read  out  1  type of the head entry; 0 when empty.
- outstanding  out  clog2(DEPTH+1)  number of valid entries.
- full  out  1  outstanding == DEPTH.
- empty  out  1  outstanding == 0.
- mismatch_err  out  1  one-cycle pulse; response source does not match the head entry.
- timeout_err  out  1  one-cycle pulse; head entry dropped on timeout.

## Operation
- Storage is a circular queue of {target, is_read}, with write and read pointers of log2(DEPTH) bits that wrap modulo DEPTH.
- Push: `req_valid && req_ready` writes the entry at the write pointer. The write pointer and count increment.
- Pop (retire): read pointer increments and count decrements.
- Push and pop in the same cycle leave the count unchanged. Push is allowed while full only if a pop occurs in the same cycle? No: `req_ready` depends on registered `full` only, so a push while full is never accepted.
- Head-side FSM:
  - **IDLE** (empty): `rsp_accept` = 0. Move to WAIT when count becomes non-zero.
  - **WAIT**: head entry awaits its response. Timer counts up each cycle.
    - `rsp_valid` with `rsp_source == head.target`: `rsp_accept` = 1 and the timer clears.
      - If `rsp_done` is also 1 (single-flit response), retire immediately: go to WAIT if the remaining count > 0, else IDLE.
      - Otherwise go to RECV.
    - `rsp_valid` with a different source: `rsp_accept` = 0 and `mismatch_err` pulses the next cycle. The entry is kept and the timer keeps running. Upstream drops the packet.
    - Timer reaches TIMEOUT-1 with no accept: `timeout_err` pulses the next cycle, the head is retired, and the timer clears.
  - **RECV**: `rsp_accept` = 0. Timer is held. `rsp_done` retires the head and selects WAIT or IDLE from the post-retire count, counting a same-cycle push.
- A new head in WAIT starts with timer = 0.
- `head_is_read` and `outstanding` are registered/queue-derived and always reflect the current head and count.
- Reset mid-operation: all entries are invalidated immediately and the FSM goes to IDLE. Any in-flight response is abandoned with no error pulse.

## Timing
- Reset values:
  - `req_ready` = 1, `rsp_accept` = 0, `head_is_read` = 0, `outstanding` = 0.
  - `full` = 0, `empty` = 1, `mismatch_err` = 0, `timeout_err` = 0.
  - FSM IDLE, pointers 0, timer 0.
- A push in cycle N makes the entry visible (`empty` = 0, `head_is_read` valid) in cycle N+1. The earliest `rsp_accept` is in cycle N+1.
- `rsp_accept` has zero latency from `rsp_valid`/`rsp_source` and is valid only in WAIT.
- A retire in cycle N updates `outstanding`, `full`, `empty` and the head in cycle N+1. A full queue shows `req_ready` = 1 in cycle N+1.
- Error pulses are registered and last exactly one cycle.
- Timeout fires after exactly TIMEOUT cycles in WAIT without an accept.

## Test plan
- **Reset and empty:** assert rst low mid-RECV with 3 entries -> all outputs at reset values while low; `outstanding` = 0 after release.
- **In-order fill and drain:** push targets 3, 7, 1, 9 (read, write, read, write) with DEPTH = 4 -> `full` = 1 and `req_ready` = 0. Further pushes are ignored. Responses 3, 7, 1, 9, each two flits, are accepted in order, and `head_is_read` follows 1, 0, 1, 0.
- **Single-flit plus simultaneous push:** 1 entry (target 5); same cycle `rsp_valid` src 5, `rsp_done` = 1 and a push of target 6 -> `outstanding` stays 1 and the head becomes 6 next cycle.
- **Mismatch:** head target 4, response src 2 -> `rsp_accept` = 0, `mismatch_err` pulses one cycle, entry kept. A later src 4 is accepted.
- **Timeout:** TIMEOUT = 8, head target 2 with no response -> `timeout_err` pulses after 8 WAIT cycles and `outstanding` decrements. The next head's timer restarts from 0.
- **Pointer wrap:** 10 push/retire pairs with DEPTH = 4 -> correct targets returned throughout, with no spurious `full` or `empty`.

Source files
------------

// File: rtl/ni_response_order_ctrl.sv
// In-order outstanding-transaction tracker: queues {target, is_read} per request and gates responses against the head.
// rsp_accept is combinational in WAIT; errors pulse one cycle later; req_ready follows the registered full flag.
module ni_response_order_ctrl #(
    parameter int DEPTH   = 4,
    parameter int SRCW    = 5,
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    input  logic                         req_is_read,
    input  logic [SRCW-1:0]              req_target,
    output logic                         req_ready,
    input  logic                         rsp_valid,
    input  logic [SRCW-1:0]              rsp_source,
    input  logic                         rsp_done,
    output logic                         rsp_accept,
    output logic                         head_is_read,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding,
    output logic                         full,
    output logic                         empty,
    output logic                         mismatch_err,
    output logic                         timeout_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [15:0]   TO_LAST  = 16'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RECV = 2'd2;

    logic [SRCW-1:0]  r_tgt [DEPTH];
    logic [DEPTH-1:0] r_rd;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_state;
    logic [15:0]      r_timer;
    logic             r_mis;
    logic             r_to;

    logic             w_push;
    logic             w_pop;
    logic             w_match;
    logic             w_timeout;
    logic [CW-1:0]    w_cnt_nxt;
    logic [1:0]       w_state_nxt;
    logic [15:0]      w_timer_nxt;

    assign full         = (r_cnt == FULL_CNT);
    assign empty        = (r_cnt == '0);
    assign req_ready    = !full;
    assign outstanding  = r_cnt;
    assign head_is_read = !empty && r_rd[r_rptr];
    assign mismatch_err = r_mis;
    assign timeout_err  = r_to;

    assign w_match    = rsp_valid && (rsp_source == r_tgt[r_rptr]);
    assign rsp_accept = (r_state == S_WAIT) && w_match;
    assign w_timeout  = (r_state == S_WAIT) && !rsp_accept && (r_timer == TO_LAST);
    assign w_push     = req_valid && !full;
    assign w_pop      = ((r_state == S_WAIT) && ((rsp_accept && rsp_done) || w_timeout))
                     || ((r_state == S_RECV) && rsp_done);
    assign w_cnt_nxt  = r_cnt + CW'(w_push) - CW'(w_pop);

    // Timer defaults to zero so every new head, and every accept, restarts it.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (w_push) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_pop)           w_state_nxt = (w_cnt_nxt != '0) ? S_WAIT : S_IDLE;
                else if (rsp_accept) w_state_nxt = S_RECV;
                else                 w_timer_nxt = r_timer + 16'd1;
            end
            S_RECV: begin
                if (w_pop) w_state_nxt = (w_cnt_nxt != '0) ? S_WAIT : S_IDLE;
                else       w_timer_nxt = r_timer;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_tgt[i] <= '0;
            r_rd    <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_timer <= '0;
            r_mis   <= 1'b0;
            r_to    <= 1'b0;
        end else begin
            if (w_push) begin
                r_tgt[r_wptr] <= req_target;
                r_rd[r_wptr]  <= req_is_read;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            r_cnt   <= w_cnt_nxt;
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_mis   <= (r_state == S_WAIT) && rsp_valid && !w_match;
            r_to    <= w_timeout;
        end
    end
endmodule

// File: tb/tb_ni_response_order_ctrl.sv
// Directed table-driven bench for ni_response_order_ctrl (DEPTH=4, SRCW=5, TIMEOUT=8).
module tb_ni_response_order_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_is_read = 1'b0;
    logic [4:0] req_target = '0;
    logic       req_ready;
    logic       rsp_valid = 1'b0;
    logic [4:0] rsp_source = '0;
    logic       rsp_done = 1'b0;
    logic       rsp_accept;
    logic       head_is_read;
    logic [2:0] outstanding;
    logic       full;
    logic       empty;
    logic       mismatch_err;
    logic       timeout_err;

    ni_response_order_ctrl #(.DEPTH(4), .SRCW(5), .TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_is_read  (req_is_read),
        .req_target   (req_target),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_source   (rsp_source),
        .rsp_done     (rsp_done),
        .rsp_accept   (rsp_accept),
        .head_is_read (head_is_read),
        .outstanding  (outstanding),
        .full         (full),
        .empty        (empty),
        .mismatch_err (mismatch_err),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rv;
        logic       rr;
        logic [4:0] rt;
        logic       sv;
        logic [4:0] ss;
        logic       sd;
        logic       acc;   // expected rsp_accept during the cycle
        logic [2:0] cnt;   // expected outstanding after the edge
        logic       hrd;   // expected head_is_read after the edge
        logic       mis;   // expected mismatch_err after the edge
        logic       tout;  // expected timeout_err after the edge
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic rv, input logic rr, input logic [4:0] rt,
                                input logic sv, input logic [4:0] ss, input logic sd,
                                input logic acc, input logic [2:0] cnt, input logic hrd,
                                input logic mis, input logic tout);
        vec_t v;
        v.rv = rv; v.rr = rr; v.rt = rt; v.sv = sv; v.ss = ss; v.sd = sd;
        v.acc = acc; v.cnt = cnt; v.hrd = hrd; v.mis = mis; v.tout = tout;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_reset(input int idx);
        chk("rst_accept",   idx, rsp_accept,   0);
        chk("rst_outstand", idx, outstanding,  0);
        chk("rst_head_rd",  idx, head_is_read, 0);
        chk("rst_mismatch", idx, mismatch_err, 0);
        chk("rst_timeout",  idx, timeout_err,  0);
        chk("rst_full",     idx, full,         0);
        chk("rst_empty",    idx, empty,        1);
        chk("rst_ready",    idx, req_ready,    1);
    endtask

    task automatic run(input vec_t v, input int idx);
        @(negedge clk);
        req_valid   = v.rv;
        req_is_read = v.rr;
        req_target  = v.rt;
        rsp_valid   = v.sv;
        rsp_source  = v.ss;
        rsp_done    = v.sd;
        #1;
        chk("rsp_accept", idx, rsp_accept, v.acc);
        @(posedge clk);
        #1;
        chk("outstanding",  idx, outstanding,  v.cnt);
        chk("head_is_read", idx, head_is_read, v.hrd);
        chk("mismatch_err", idx, mismatch_err, v.mis);
        chk("timeout_err",  idx, timeout_err,  v.tout);
        chk("full",         idx, full,         v.cnt == 3'd4);
        chk("empty",        idx, empty,        v.cnt == 3'd0);
        chk("req_ready",    idx, req_ready,    v.cnt != 3'd4);
    endtask

    initial begin
        logic [4:0] tg[10];
        logic       rd[10];

        // Fill to full (push while full ignored), then drain with two-flit responses.
        tbl.push_back(mk(1,1,3,  0,0,0, 0,1,1,0,0));
        tbl.push_back(mk(1,0,7,  0,0,0, 0,2,1,0,0));
        tbl.push_back(mk(1,1,1,  0,0,0, 0,3,1,0,0));
        tbl.push_back(mk(1,0,9,  0,0,0, 0,4,1,0,0));
        tbl.push_back(mk(1,1,11, 0,0,0, 0,4,1,0,0));
        tbl.push_back(mk(0,0,0,  1,3,0, 1,4,1,0,0));
        tbl.push_back(mk(1,1,11, 0,0,1, 0,3,0,0,0));
        tbl.push_back(mk(0,0,0,  1,7,0, 1,3,0,0,0));
        tbl.push_back(mk(0,0,0,  0,0,1, 0,2,1,0,0));
        tbl.push_back(mk(0,0,0,  1,1,0, 1,2,1,0,0));
        tbl.push_back(mk(0,0,0,  0,0,1, 0,1,0,0,0));
        tbl.push_back(mk(0,0,0,  1,9,0, 1,1,0,0,0));
        tbl.push_back(mk(0,0,0,  0,0,1, 0,0,0,0,0));
        // Single-flit retire with a same-cycle push.
        tbl.push_back(mk(1,0,5,  0,0,0, 0,1,0,0,0));
        tbl.push_back(mk(1,1,6,  1,5,1, 1,1,1,0,0));
        tbl.push_back(mk(0,0,0,  1,6,1, 1,0,0,0,0));
        // Mismatch then correct source.
        tbl.push_back(mk(1,1,4,  0,0,0, 0,1,1,0,0));
        tbl.push_back(mk(0,0,0,  1,2,0, 0,1,1,1,0));
        tbl.push_back(mk(0,0,0,  0,0,0, 0,1,1,0,0));
        tbl.push_back(mk(0,0,0,  1,4,1, 1,0,0,0,0));
        // Timeout on head 2 after 8 WAIT cycles, then on head 12 after a fresh 8.
        tbl.push_back(mk(1,0,2,  0,0,0, 0,1,0,0,0));
        tbl.push_back(mk(1,1,12, 0,0,0, 0,2,0,0,0));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(0,0,0, 0,0,0, 0,2,0,0,0));
        tbl.push_back(mk(0,0,0,  0,0,0, 0,1,1,0,1));
        for (int i = 0; i < 7; i++) tbl.push_back(mk(0,0,0, 0,0,0, 0,1,1,0,0));
        tbl.push_back(mk(0,0,0,  0,0,0, 0,0,0,0,1));
        tbl.push_back(mk(0,0,0,  0,0,0, 0,0,0,0,0));
        // Pointer wrap: 10 overlapping push/retire pairs.
        for (int i = 0; i < 10; i++) begin
            tg[i] = 5'(i * 3 + 2);
            rd[i] = logic'(i % 2);
        end
        tbl.push_back(mk(1,rd[0],tg[0], 0,0,0, 0,1,rd[0],0,0));
        for (int k = 1; k < 10; k++)
            tbl.push_back(mk(1,rd[k],tg[k], 1,tg[k-1],1, 1,1,rd[k],0,0));
        tbl.push_back(mk(0,0,0, 1,tg[9],1, 1,0,0,0,0));

        repeat (2) @(posedge clk);
        #1;
        chk_reset(-1);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) run(tbl[i], i);

        // Reset asserted mid-RECV with three entries queued.
        run(mk(1,1,3, 0,0,0, 0,1,1,0,0), 100);
        run(mk(1,0,7, 0,0,0, 0,2,1,0,0), 101);
        run(mk(1,1,1, 0,0,0, 0,3,1,0,0), 102);
        run(mk(0,0,0, 1,3,0, 1,3,1,0,0), 103);
        @(negedge clk);
        rst        = 1'b0;
        req_valid  = 1'b1;
        req_target = 5'd4;
        rsp_valid  = 1'b1;
        rsp_source = 5'd7;
        rsp_done   = 1'b0;
        #1;
        chk_reset(104);
        @(posedge clk);
        #1;
        chk_reset(105);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_reset(106);
        run(mk(1,1,8, 0,0,0, 0,1,1,0,0), 107);
        run(mk(0,0,0, 1,8,1, 1,0,0,0,0), 108);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
